// File: rtl/read_memory.sv
// Merge-side reader: after the writer finishes a round, drains each slot's
// address-info FIFO in slot order and streams every RAM span as one frame.
module read_memory #(
  parameter int RAM_AW       = 8,
  parameter int DATA_WIDTH   = 24,
  parameter int FDSSI_WIDTH  = 12,
  parameter int TAM_WIDTH    = 2,
  parameter int INFO_WIDTH   = FDSSI_WIDTH + 2 * RAM_AW,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 addr_finish,
  output logic                                 merge_finish,
  input  logic [(2**TAM_WIDTH)-1:0]            s_addr_info_tvalid,
  output logic [(2**TAM_WIDTH)-1:0]            s_addr_info_tready,
  input  logic [(2**TAM_WIDTH)*INFO_WIDTH-1:0] s_addr_info,
  output logic                                 ram_ren,
  output logic [RAM_AW-1:0]                    ram_raddr,
  input  logic [DATA_WIDTH-1:0]                ram_dout,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic [DATA_WIDTH-1:0]                m_tdata,
  output logic [FDSSI_WIDTH-1:0]               m_fdssi,
  output logic [TAM_WIDTH-1:0]                 m_slot
);

  localparam int N  = 2 ** TAM_WIDTH;
  localparam int LW = RAM_AW + 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0]        GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [TAM_WIDTH-1:0] SLOT_LAST  = TAM_WIDTH'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GUARD    = 3'd1,
    S_SELECT   = 3'd2,
    S_READ     = 3'd3,
    S_DONE     = 3'd4,
    S_WAIT_CLR = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [TAM_WIDTH-1:0]   slot_r;
  logic [GW-1:0]          guard_cnt_r;
  logic [RAM_AW-1:0]      rd_addr_r;
  logic [LW-1:0]          len_r;
  logic [LW-1:0]          issued_r;
  logic                   dv_r;
  logic                   dv_last_r;
  logic                   head_valid_r;
  logic                   head_last_r;
  logic [DATA_WIDTH-1:0]  head_data_r;
  logic                   skid_valid_r;
  logic                   skid_last_r;
  logic [DATA_WIDTH-1:0]  skid_data_r;
  logic [FDSSI_WIDTH-1:0] fdssi_r;
  logic [TAM_WIDTH-1:0]   frame_slot_r;
  logic                   merge_finish_r;

  logic [INFO_WIDTH-1:0]  entry_s;
  logic [FDSSI_WIDTH-1:0] entry_fdssi_s;
  logic [RAM_AW-1:0]      entry_saddr_s;
  logic [RAM_AW-1:0]      entry_eaddr_s;
  logic                   sel_valid_s;
  logic                   pop_s;
  logic                   hs_s;
  logic                   frame_done_s;
  logic [1:0]             pending_s;
  logic                   issue_s;
  logic                   issue_last_s;
  logic [N-1:0]           tready_s;

  // Slot entry decode, handshakes and the read-credit rule (buffer + in flight <= 2)
  always_comb begin
    entry_s       = s_addr_info[slot_r*INFO_WIDTH +: INFO_WIDTH];
    entry_fdssi_s = entry_s[INFO_WIDTH-1 -: FDSSI_WIDTH];
    entry_saddr_s = entry_s[2*RAM_AW-1 -: RAM_AW];
    entry_eaddr_s = entry_s[RAM_AW-1:0];
    sel_valid_s   = s_addr_info_tvalid[slot_r];
    pop_s         = (state_r == S_SELECT) && sel_valid_s;
    hs_s          = head_valid_r && m_tready;
    frame_done_s  = hs_s && head_last_r;
    // occupancy after this cycle's pop plus the word currently on ram_dout
    pending_s     = 2'(head_valid_r) + 2'(skid_valid_r) + 2'(dv_r) - 2'(hs_s);
    issue_s       = (state_r == S_READ) && (issued_r != len_r) && (pending_s < 2'd2);
    issue_last_s  = (issued_r == (len_r - LW'(1)));
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and slot pop strobe
  always_comb begin
    state_s  = state_r;
    tready_s = {N{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (addr_finish) state_s = S_GUARD;
        else             state_s = S_IDLE;
      end
      S_GUARD: begin
        if (guard_cnt_r == GUARD_LAST) state_s = S_SELECT;
        else                           state_s = S_GUARD;
      end
      S_SELECT: begin
        if (sel_valid_s) begin
          tready_s[slot_r] = 1'b1;
          state_s          = S_READ;
        end else if (slot_r == SLOT_LAST) begin
          state_s = S_DONE;
        end else begin
          state_s = S_SELECT;
        end
      end
      S_READ: begin
        if (frame_done_s) state_s = S_SELECT;
        else              state_s = S_READ;
      end
      S_DONE: begin
        state_s = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!addr_finish) state_s = S_IDLE;
        else              state_s = S_WAIT_CLR;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Round control, frame latch and RAM read sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      merge_finish_r <= 1'b0;
      guard_cnt_r    <= {GW{1'b0}};
      slot_r         <= {TAM_WIDTH{1'b0}};
      rd_addr_r      <= {RAM_AW{1'b0}};
      len_r          <= {LW{1'b0}};
      issued_r       <= {LW{1'b0}};
      fdssi_r        <= {FDSSI_WIDTH{1'b0}};
      frame_slot_r   <= {TAM_WIDTH{1'b0}};
      dv_r           <= 1'b0;
      dv_last_r      <= 1'b0;
    end else begin
      merge_finish_r <= (state_s == S_DONE);

      if (state_r == S_GUARD) guard_cnt_r <= guard_cnt_r + GW'(1);
      else                    guard_cnt_r <= {GW{1'b0}};

      if ((state_r == S_IDLE) && addr_finish) begin
        slot_r <= {TAM_WIDTH{1'b0}};
      end else if ((state_r == S_SELECT) && !sel_valid_s && (slot_r != SLOT_LAST)) begin
        slot_r <= slot_r + TAM_WIDTH'(1);
      end

      if (pop_s) begin
        rd_addr_r    <= entry_saddr_s;
        // span length is modular, so e = s-1 covers the whole RAM
        len_r        <= {1'b0, entry_eaddr_s - entry_saddr_s} + LW'(1);
        issued_r     <= {LW{1'b0}};
        fdssi_r      <= entry_fdssi_s;
        frame_slot_r <= slot_r;
      end else if (issue_s) begin
        rd_addr_r <= rd_addr_r + RAM_AW'(1);
        issued_r  <= issued_r + LW'(1);
      end

      dv_r      <= issue_s;
      dv_last_r <= issue_s && issue_last_s;
    end
  end

  // Two-entry output buffer: head drives the stream, skid absorbs one stalled word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_valid_r <= 1'b0;
      head_last_r  <= 1'b0;
      head_data_r  <= {DATA_WIDTH{1'b0}};
      skid_valid_r <= 1'b0;
      skid_last_r  <= 1'b0;
      skid_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (!head_valid_r || hs_s) begin
      if (skid_valid_r) begin
        head_valid_r <= 1'b1;
        head_last_r  <= skid_last_r;
        head_data_r  <= skid_data_r;
        skid_valid_r <= dv_r;
        skid_last_r  <= dv_last_r;
        skid_data_r  <= ram_dout;
      end else if (dv_r) begin
        head_valid_r <= 1'b1;
        head_last_r  <= dv_last_r;
        head_data_r  <= ram_dout;
      end else begin
        head_valid_r <= 1'b0;
        head_last_r  <= 1'b0;
      end
    end else if (dv_r) begin
      skid_valid_r <= 1'b1;
      skid_last_r  <= dv_last_r;
      skid_data_r  <= ram_dout;
    end
  end

  assign merge_finish       = merge_finish_r;
  assign s_addr_info_tready = tready_s;
  assign ram_ren            = issue_s;
  assign ram_raddr          = rd_addr_r;
  assign m_tvalid           = head_valid_r;
  assign m_tlast            = head_last_r;
  assign m_tdata            = head_data_r;
  assign m_fdssi            = fdssi_r;
  assign m_slot             = frame_slot_r;

endmodule

// File: tb/tb_read_memory.sv
// Self-checking bench for read_memory: per-slot FIFO and RAM models, randomized
// frames and backpressure, checked against a span/word reference model.
module tb_read_memory;

  localparam int AW = 8;
  localparam int DW = 24;
  localparam int FW = 12;
  localparam int TW = 2;
  localparam int NS = 4;
  localparam int IW = FW + 2 * AW;
  localparam int WW = DW + 1 + FW + TW;

  logic             clk = 1'b0;
  logic             reset;
  logic             addr_finish;
  logic             merge_finish;
  logic [NS-1:0]    tvalid;
  logic [NS-1:0]    tready;
  logic [NS*IW-1:0] info;
  logic             ram_ren;
  logic [AW-1:0]    ram_raddr;
  logic [DW-1:0]    ram_dout;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [DW-1:0]    m_tdata;
  logic [FW-1:0]    m_fdssi;
  logic [TW-1:0]    m_slot;

  read_memory #(
    .RAM_AW(AW), .DATA_WIDTH(DW), .FDSSI_WIDTH(FW), .TAM_WIDTH(TW),
    .INFO_WIDTH(IW), .GUARD_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .addr_finish(addr_finish), .merge_finish(merge_finish),
    .s_addr_info_tvalid(tvalid), .s_addr_info_tready(tready), .s_addr_info(info),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .m_fdssi(m_fdssi), .m_slot(m_slot)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rmode = 0;
  int merge_cnt = 0;
  int first_pop = -1, first_ren = -1, first_vld = -1;
  logic [AW-1:0] first_raddr;
  int oh_viol = 0, stab_viol = 0, occ_viol = 0, pop_err = 0;
  int iss = 0, acc = 0;

  logic [DW-1:0] mem [256];
  logic [IW-1:0] slot_q [NS][$];
  logic [WW-1:0] exp_q [$];
  logic [WW-1:0] obs_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] ent(input logic [FW-1:0] f, input logic [AW-1:0] s,
                                         input logic [AW-1:0] e);
    return {f, s, e};
  endfunction

  // RAM model: one-cycle read latency
  always @(posedge clk) if (ram_ren) ram_dout <= mem[ram_raddr];

  initial forever @(posedge clk) cyc++;

  // Backpressure driver
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Per-slot FIFO model: pops on tready, presents head entry
  initial begin
    logic [NS-1:0]    pm;
    logic [NS-1:0]    tv;
    logic [NS*IW-1:0] inf;
    tvalid = '0;
    info   = '0;
    forever begin
      @(negedge clk);
      pm = tready;
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (pm[i]) begin
          if (slot_q[i].size() > 0) void'(slot_q[i].pop_front());
          else pop_err++;
        end
      end
      tv  = '0;
      inf = '0;
      for (int i = 0; i < NS; i++) begin
        if (slot_q[i].size() > 0) begin
          tv[i] = 1'b1;
          inf[i*IW +: IW] = slot_q[i][0];
        end
      end
      tvalid = tv;
      info   = inf;
    end
  end

  // Stream monitor
  initial begin
    logic          prev_v;
    logic          prev_hs;
    logic          hs;
    logic [WW-1:0] prev_w;
    logic [WW-1:0] cur_w;
    prev_v = 1'b0; prev_hs = 1'b0; prev_w = '0;
    forever begin
      @(negedge clk);
      cur_w = {m_tdata, m_tlast, m_fdssi, m_slot};
      if (reset) begin
        iss = 0; acc = 0; prev_v = 1'b0; prev_hs = 1'b0;
      end else begin
        if ($countones(tready) > 1) oh_viol++;
        if (tready != '0 && first_pop < 0) first_pop = cyc;
        if (ram_ren && first_ren < 0) begin first_ren = cyc; first_raddr = ram_raddr; end
        if (m_tvalid && first_vld < 0) first_vld = cyc;
        if (merge_finish) merge_cnt++;
        if (prev_v && !prev_hs && (!m_tvalid || cur_w != prev_w)) stab_viol++;
        hs = m_tvalid && m_tready;
        if (ram_ren) iss++;
        if (hs) begin acc++; obs_q.push_back(cur_w); end
        if (iss - acc > 2) occ_viol++;
        prev_v = m_tvalid; prev_hs = hs; prev_w = cur_w;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // Expected stream: slots in order, each entry a modular span of RAM words
  task automatic build_expected();
    logic [IW-1:0] e;
    logic [FW-1:0] f;
    int sa, ea, len, addr;
    exp_q.delete();
    for (int sl = 0; sl < NS; sl++) begin
      for (int j = 0; j < slot_q[sl].size(); j++) begin
        e   = slot_q[sl][j];
        f   = e[IW-1 -: FW];
        sa  = int'(e[2*AW-1 -: AW]);
        ea  = int'(e[AW-1:0]);
        len = ((ea - sa + 256) % 256) + 1;
        for (int k = 0; k < len; k++) begin
          addr = (sa + k) % 256;
          exp_q.push_back({mem[addr], (k == len - 1), f, TW'(sl)});
        end
      end
    end
  endtask

  task automatic run_round(input int mode, input bit drop_early, input bit check_lat,
                           input logic [AW-1:0] lat_saddr);
    int c;
    int af_cyc;
    int left;
    build_expected();
    obs_q.delete();
    merge_cnt = 0; first_pop = -1; first_ren = -1; first_vld = -1;
    rmode = mode;
    @(posedge clk); #1;
    addr_finish = 1'b1;
    af_cyc = cyc;
    if (drop_early) begin
      c = 0;
      while (obs_q.size() == 0 && c < 2000) begin @(posedge clk); c++; end
      #1 addr_finish = 1'b0;
    end
    c = 0;
    while (merge_cnt == 0 && c < 5000) begin @(posedge clk); c++; end
    check("merge_seen", (merge_cnt > 0), 1);
    repeat (8) @(posedge clk);
    check("merge_once", merge_cnt, 1);
    check("no_second_round", obs_q.size(), exp_q.size());
    #1 addr_finish = 1'b0;
    repeat (4) @(posedge clk);
    check("frame_words", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check("word", obs_q[i], exp_q[i]);
    end
    left = 0;
    for (int sl = 0; sl < NS; sl++) left += slot_q[sl].size();
    check("entries_left", left, 0);
    check("pop_empty", pop_err, 0);
    check("tready_onehot", oh_viol, 0);
    check("data_stable", stab_viol, 0);
    check("occupancy", occ_viol, 0);
    if (check_lat) begin
      check("select_latency", first_pop - af_cyc, 3);
      check("ren_latency", first_ren - first_pop, 1);
      check("ren_addr", first_raddr, lat_saddr);
      check("valid_latency", first_vld - first_pop, 3);
    end
  endtask

  initial begin
    logic [AW-1:0] s;
    int c;
    int n;
    int l;
    reset = 1'b0;
    addr_finish = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a);
    #1 reset = 1'b1;
    #2;
    check("reset_outputs", {merge_finish, tready, ram_ren, ram_raddr, m_tvalid, m_tlast,
                            m_tdata, m_fdssi, m_slot}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic 4-word frame from slot 0 with RAM[a] = a
    slot_q[0].push_back(ent(12'h005, 8'h10, 8'h13));
    repeat (2) @(posedge clk);
    run_round(0, 1'b0, 1'b1, 8'h10);

    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);

    // Wrap-around span and single-word span
    slot_q[0].push_back(ent(FW'($urandom), 8'hFE, 8'h01));
    slot_q[3].push_back(ent(FW'($urandom), 8'h40, 8'h40));
    repeat (2) @(posedge clk);
    run_round(0, 1'b0, 1'b0, 8'h00);

    // 8-word frame under alternating backpressure
    s = AW'($urandom);
    slot_q[1].push_back(ent(FW'($urandom), s, s + 8'd7));
    repeat (2) @(posedge clk);
    run_round(1, 1'b0, 1'b0, 8'h00);

    // Multi-slot ordering, addr_finish dropped mid-round
    for (int j = 0; j < 2; j++) begin
      s = AW'($urandom);
      slot_q[2].push_back(ent(FW'($urandom), s, s + AW'($urandom_range(0, 6))));
    end
    s = AW'($urandom);
    slot_q[1].push_back(ent(FW'($urandom), s, s + AW'($urandom_range(0, 6))));
    repeat (2) @(posedge clk);
    run_round(2, 1'b1, 1'b0, 8'h00);

    // Whole-RAM frame (e = s - 1) with random backpressure
    s = AW'($urandom);
    slot_q[3].push_back(ent(FW'($urandom), s, s - 8'd1));
    repeat (2) @(posedge clk);
    run_round(2, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of a 6-word frame
    s = AW'($urandom);
    slot_q[0].push_back(ent(FW'($urandom), s, s + 8'd5));
    repeat (2) @(posedge clk);
    rmode = 0;
    obs_q.delete();
    @(posedge clk); #1 addr_finish = 1'b1;
    c = 0;
    while (obs_q.size() < 3 && c < 200) begin @(posedge clk); c++; end
    check("pre_reset_words", (obs_q.size() >= 3), 1);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    check("midframe_reset_outputs", {merge_finish, tready, ram_ren, ram_raddr, m_tvalid,
                                     m_tlast, m_tdata, m_fdssi, m_slot}, 0);
    addr_finish = 1'b0;
    for (int sl = 0; sl < NS; sl++) slot_q[sl].delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Random rounds, including the first one after reset
    for (int r = 0; r < 4; r++) begin
      for (int sl = 0; sl < NS; sl++) begin
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) begin
          s = AW'($urandom);
          l = $urandom_range(1, 10);
          slot_q[sl].push_back(ent(FW'($urandom), s, s + AW'(l - 1)));
        end
      end
      repeat (2) @(posedge clk);
      run_round($urandom_range(0, 2), r[0], 1'b0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
